display_scan: RTL

Multiplexed 4-digit 7-segment scanner for the irrigation countdown timer. It sits directly downstream of the MM:SS countdown: it consumes the four BCD digits (Dmin, Umin, Dseg, Useg), snapshots them once per frame so the display never tears, and drives the shared segment bus and the per-digit anodes. It also provides a colon indicator and a blink mode used when the timer signals expiry.

---
 rtl/display_pkg.sv | 27 ++
 rtl/bcd_to_7seg.sv | 28 ++
 rtl/display_scan.sv | 120 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 4-digit 7-segment scanner: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the digit-slot indices used to select
// the anodes.
package display_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Slot index == anode bit that lights the digit.
    localparam logic [1:0] SLOT_USEG = 2'd0;
    localparam logic [1:0] SLOT_DSEG = 2'd1;
    localparam logic [1:0] SLOT_UMIN = 2'd2;
    localparam logic [1:0] SLOT_DMIN = 2'd3;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder. Non-BCD codes
// (A..F) render as a dash so corrupt upstream data is visible.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit lookup with dash fallback.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 4-digit 7-segment scanner for the MM:SS countdown.
// Digits are snapshotted once per frame (at the last tick of slot 3) so a
// frame never mixes old and new values. Outputs are registered and lag the
// scan state by one clock. A blink level blanks all anodes for alternating
// groups of BLINK_FRAMES frames, starting visible.
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank a zero tens-of-minutes
// digit (anode still driven) so 09:59 reads " 9:59".
module display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Dmin,
    input  logic [3:0] Umin,
    input  logic [3:0] Dseg,
    input  logic [3:0] Useg,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]   pcnt;
    logic [1:0]      idx;
    logic            tick;
    logic            frame_start;
    logic [3:0][3:0] snap;       // indexed by slot
    logic [FW-1:0]   fcnt;
    logic            bphase;
    logic            blank;
    logic [3:0]      digit;
    logic [6:0]      dec_seg;
    logic [6:0]      seg_next;

    assign tick        = (pcnt == PCNT_MAX);
    assign frame_start = tick && (idx == SLOT_DMIN);
    // Live blink term: dropping blink unblanks on the very next update.
    assign blank       = blink && bphase;
    assign digit       = snap[idx];

    bcd_to_7seg u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    // Segment pattern for the current slot, with optional leading-zero blank.
    always_comb begin
        seg_next = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx == SLOT_DMIN) && (digit == 4'd0)) begin
            seg_next = SEG_OFF;
        end
`endif
    end

    // Prescaler and slot index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= SLOT_USEG;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Frame snapshot of the four BCD digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap <= '0;
        end else if (frame_start) begin
            snap[SLOT_USEG] <= Useg;
            snap[SLOT_DSEG] <= Dseg;
            snap[SLOT_UMIN] <= Umin;
            snap[SLOT_DMIN] <= Dmin;
        end
    end

    // Blink frame counter and phase; held at zero while blink is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt   <= '0;
            bphase <= 1'b0;
        end else if (!blink) begin
            fcnt   <= '0;
            bphase <= 1'b0;
        end else if (frame_start) begin
            if (fcnt == FCNT_MAX) begin
                fcnt   <= '0;
                bphase <= ~bphase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Registered segment, anode and colon outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
            dp  <= 1'b1;
        end else begin
            seg <= seg_next;
            an  <= blank ? AN_OFF : ~(4'b0001 << idx);
            dp  <= !((idx == SLOT_UMIN) && !blank);
        end
    end

endmodule
